rggen_irq_arbiter: RTL and testbench

Round-robin interrupt arbiter with acknowledge/end-of-interrupt handshake, placed between the register block's interrupt enable/status fields and a single CPU interrupt line. Each enabled-and-set source is presented as one numbered request. The request is held stable until the CPU acknowledges it and is then tracked as in-service until the CPU signals end-of-interrupt. Sources are rotated fairly, so a continuously asserted source cannot starve others.

---
 rtl/rggen_irq_arbiter_pkg.sv | 16 +
 rtl/rggen_irq_rr_selector.sv | 37 +++
 rtl/rggen_irq_arbiter.sv | 122 ++++++++++++
 tb/tb_rggen_irq_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rggen_irq_arbiter_pkg.sv
// Shared types and helpers for the round-robin interrupt arbiter.
// Imported by the arbiter top level and its selector.
package rggen_irq_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  // Width of every ID port; a single source still needs one bit.
  function automatic int calc_id_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/rggen_irq_rr_selector.sv
// Combinational round-robin pick: rotate pending by ptr, find first one,
// then un-rotate the offset back into a source ID.
module rggen_irq_rr_selector
  import rggen_irq_arbiter_pkg::*;
#(
  parameter int TOTAL_INTERRUPTS = 1,
  parameter int ID_WIDTH         = calc_id_width(TOTAL_INTERRUPTS)
) (
  input  logic [TOTAL_INTERRUPTS-1:0] pending,
  input  logic [ID_WIDTH-1:0]         ptr,
  output logic                        found,
  output logic [ID_WIDTH-1:0]         sel_id
);

  logic [TOTAL_INTERRUPTS-1:0] rotated;
  int                          offset;
  int                          id_sum;

  always_comb begin
    // ptr never exceeds TOTAL_INTERRUPTS-1, so a double-width shift is a rotate.
    rotated = TOTAL_INTERRUPTS'({pending, pending} >> ptr);
    found   = 1'b0;
    offset  = 0;
    for (int i = 0; i < TOTAL_INTERRUPTS; i++) begin
      if (!found && rotated[i]) begin
        found  = 1'b1;
        offset = i;
      end
    end
    id_sum = int'(ptr) + offset;
    if (id_sum >= TOTAL_INTERRUPTS) begin
      id_sum = id_sum - TOTAL_INTERRUPTS;
    end
    sel_id = ID_WIDTH'(id_sum);
  end

endmodule

// File: rtl/rggen_irq_arbiter.sv
// Round-robin interrupt arbiter with ack / end-of-interrupt handshake.
// All outputs come straight from registers.
module rggen_irq_arbiter
  import rggen_irq_arbiter_pkg::*;
#(
  parameter int TOTAL_INTERRUPTS = 1,
  parameter int ID_WIDTH         = calc_id_width(TOTAL_INTERRUPTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [TOTAL_INTERRUPTS-1:0] i_ier,
  input  logic [TOTAL_INTERRUPTS-1:0] i_isr,
  input  logic                        i_ack,
  input  logic                        i_eoi,
  output logic                        o_irq,
  output logic [ID_WIDTH-1:0]         o_irq_id,
  output logic                        o_busy,
  output logic [ID_WIDTH-1:0]         o_service_id
);

  // Handshake: o_irq holds with a frozen o_irq_id until an i_ack pulse;
  // o_busy then holds o_service_id until an i_eoi pulse. Pulses seen in
  // any other state are ignored.

  irq_state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]         ptr_q, ptr_d;
  logic                        irq_q, irq_d;
  logic [ID_WIDTH-1:0]         irq_id_q, irq_id_d;
  logic                        busy_q, busy_d;
  logic [ID_WIDTH-1:0]         service_id_q, service_id_d;

  logic [TOTAL_INTERRUPTS-1:0] pending;
  logic [TOTAL_INTERRUPTS-1:0] presented_mask;
  logic                        presented_pending;
  logic                        found;
  logic [ID_WIDTH-1:0]         sel_id;

  assign pending           = i_ier & i_isr;
  assign presented_mask    = TOTAL_INTERRUPTS'(1) << irq_id_q;
  assign presented_pending = |(pending & presented_mask);

  rggen_irq_rr_selector #(
    .TOTAL_INTERRUPTS (TOTAL_INTERRUPTS),
    .ID_WIDTH         (ID_WIDTH)
  ) u_selector (
    .pending (pending),
    .ptr     (ptr_q),
    .found   (found),
    .sel_id  (sel_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      irq_q        <= 1'b0;
      irq_id_q     <= '0;
      busy_q       <= 1'b0;
      service_id_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      irq_q        <= irq_d;
      irq_id_q     <= irq_id_d;
      busy_q       <= busy_d;
      service_id_q <= service_id_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    irq_d        = irq_q;
    irq_id_d     = irq_id_q;
    busy_d       = busy_q;
    service_id_d = service_id_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          irq_id_d = sel_id;
          irq_d    = 1'b1;
          state_d  = PEND;
        end
      end
      PEND: begin
        // Ack takes priority over a withdrawal in the same cycle.
        if (i_ack) begin
          service_id_d = irq_id_q;
          irq_d        = 1'b0;
          busy_d       = 1'b1;
          state_d      = SVC;
        end else if (!presented_pending) begin
          irq_d   = 1'b0;
          state_d = IDLE;
        end
      end
      SVC: begin
        if (i_eoi) begin
          // Served source goes to the back of the rotation.
          if (service_id_q == ID_WIDTH'(TOTAL_INTERRUPTS - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = service_id_q + ID_WIDTH'(1);
          end
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign o_irq        = irq_q;
  assign o_irq_id     = irq_id_q;
  assign o_busy       = busy_q;
  assign o_service_id = service_id_q;

endmodule

// File: tb/tb_rggen_irq_arbiter.sv
// Directed bench for rggen_irq_arbiter: an 8-source instance driven from a
// vector table plus hand sequences, and a 1-source instance.
module tb_rggen_irq_arbiter;

  logic       clk;
  logic       rst_n;
  logic [7:0] ier;
  logic [7:0] isr;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] irq_id;
  logic       busy;
  logic [2:0] service_id;

  logic [0:0] ier1;
  logic [0:0] isr1;
  logic       ack1;
  logic       eoi1;
  logic       irq1;
  logic [0:0] irq_id1;
  logic       busy1;
  logic [0:0] service_id1;

  int tests;
  int failed;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] ier;
    logic [7:0] isr;
    logic       ack;
    logic       eoi;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  rggen_irq_arbiter #(.TOTAL_INTERRUPTS(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ier        (ier),
    .i_isr        (isr),
    .i_ack        (ack),
    .i_eoi        (eoi),
    .o_irq        (irq),
    .o_irq_id     (irq_id),
    .o_busy       (busy),
    .o_service_id (service_id)
  );

  rggen_irq_arbiter #(.TOTAL_INTERRUPTS(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ier        (ier1),
    .i_isr        (isr1),
    .i_ack        (ack1),
    .i_eoi        (eoi1),
    .o_irq        (irq1),
    .o_irq_id     (irq_id1),
    .o_busy       (busy1),
    .o_service_id (service_id1)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed outputs: {irq, irq_id[2:0], busy, service_id[2:0]}
  function automatic logic [7:0] pk(input logic i, input logic [2:0] id,
                                    input logic b, input logic [2:0] s);
    return {i, id, b, s};
  endfunction

  function automatic logic [7:0] outs8();
    return {irq, irq_id, busy, service_id};
  endfunction

  function automatic logic [7:0] outs1();
    return {4'b0, irq1, irq_id1, busy1, service_id1};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] v_ier, input logic [7:0] v_isr,
                     input logic v_ack, input logic v_eoi,
                     input logic e_irq, input logic [2:0] e_id,
                     input logic e_busy, input logic [2:0] e_svc);
    vec_t v;
    v.ier = v_ier;
    v.isr = v_isr;
    v.ack = v_ack;
    v.eoi = v_eoi;
    v.exp = pk(e_irq, e_id, e_busy, e_svc);
    vecs.push_back(v);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    ier    = '0;
    isr    = '0;
    ack    = 1'b0;
    eoi    = 1'b0;
    ier1   = '0;
    isr1   = '0;
    ack1   = 1'b0;
    eoi1   = 1'b0;

    // Each row: inputs applied, one edge, then expected registered outputs.
    // Single source 4: request, ack, eoi (ptr -> 5)
    add(8'hFF, 8'h10, 0, 0,  1, 3'd4, 0, 3'd0);
    add(8'hFF, 8'h10, 1, 0,  0, 3'd4, 1, 3'd4);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd4, 0, 3'd4);
    // ptr=5 with sources 0 and 4 pending: search 5,6,7,0 -> 0 (ptr -> 1)
    add(8'hFF, 8'h11, 0, 0,  1, 3'd0, 0, 3'd4);
    add(8'hFF, 8'h11, 1, 0,  0, 3'd0, 1, 3'd0);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd0, 0, 3'd0);
    // Serve 7 so ptr wraps to 0
    add(8'hFF, 8'h80, 0, 0,  1, 3'd7, 0, 3'd0);
    add(8'hFF, 8'h80, 1, 0,  0, 3'd7, 1, 3'd7);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd7, 0, 3'd7);
    // Fairness with 0 and 7 held: served 0, 7, 0
    add(8'hFF, 8'h81, 0, 0,  1, 3'd0, 0, 3'd7);
    add(8'hFF, 8'h81, 1, 0,  0, 3'd0, 1, 3'd0);
    add(8'hFF, 8'h81, 0, 1,  0, 3'd0, 0, 3'd0);
    add(8'hFF, 8'h81, 0, 0,  1, 3'd7, 0, 3'd0);
    add(8'hFF, 8'h81, 1, 0,  0, 3'd7, 1, 3'd7);
    add(8'hFF, 8'h81, 0, 1,  0, 3'd7, 0, 3'd7);
    add(8'hFF, 8'h81, 0, 0,  1, 3'd0, 0, 3'd7);
    add(8'hFF, 8'h81, 1, 0,  0, 3'd0, 1, 3'd0);
    add(8'hFF, 8'h81, 0, 1,  0, 3'd0, 0, 3'd0);
    // Wrap: serve 7 -> ptr 0, then 8'h06 -> 1 (ptr -> 2)
    add(8'hFF, 8'h80, 0, 0,  1, 3'd7, 0, 3'd0);
    add(8'hFF, 8'h80, 1, 0,  0, 3'd7, 1, 3'd7);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd7, 0, 3'd7);
    add(8'hFF, 8'h06, 0, 0,  1, 3'd1, 0, 3'd7);
    add(8'hFF, 8'h06, 1, 0,  0, 3'd1, 1, 3'd1);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd1, 0, 3'd1);
    // Spurious eoi in PEND and ack in SVC are ignored (ptr -> 4)
    add(8'hFF, 8'h08, 0, 0,  1, 3'd3, 0, 3'd1);
    add(8'hFF, 8'h08, 0, 1,  1, 3'd3, 0, 3'd1);
    add(8'hFF, 8'h08, 1, 0,  0, 3'd3, 1, 3'd3);
    add(8'hFF, 8'h08, 1, 0,  0, 3'd3, 1, 3'd3);
    add(8'hFF, 8'h08, 0, 1,  0, 3'd3, 0, 3'd3);
    // Withdrawal: ID 3 presented, ier[3] cleared, 5 pending -> IDLE then 5
    add(8'hFF, 8'h08, 0, 0,  1, 3'd3, 0, 3'd3);
    add(8'hF7, 8'h28, 0, 0,  0, 3'd3, 0, 3'd3);
    add(8'hF7, 8'h28, 0, 0,  1, 3'd5, 0, 3'd3);
    add(8'hF7, 8'h28, 1, 0,  0, 3'd5, 1, 3'd5);
    add(8'hFF, 8'h00, 0, 1,  0, 3'd5, 0, 3'd5);
    // Withdrawal together with ack: ack wins (ptr 6 -> 3 picked, then ptr 4)
    add(8'hFF, 8'h08, 0, 0,  1, 3'd3, 0, 3'd5);
    add(8'hF7, 8'h08, 1, 0,  0, 3'd3, 1, 3'd3);
    add(8'hF7, 8'h00, 0, 1,  0, 3'd3, 0, 3'd3);
    // Other pending bits changing in PEND do not move the presented ID
    add(8'hFF, 8'h08, 0, 0,  1, 3'd3, 0, 3'd3);
    add(8'hFF, 8'h18, 0, 0,  1, 3'd3, 0, 3'd3);
    add(8'hFF, 8'h18, 1, 0,  0, 3'd3, 1, 3'd3);

    // Reset state
    step();
    step();
    check("reset_outputs", outs8(), 8'h00);
    check("reset_outputs_n1", outs1(), 8'h00);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      ier = vecs[i].ier;
      isr = vecs[i].isr;
      ack = vecs[i].ack;
      eoi = vecs[i].eoi;
      exp_q.push_back(vecs[i].exp);
      step();
      check($sformatf("vec%0d", i), outs8(), exp_q.pop_front());
    end
    ack = 1'b0;
    eoi = 1'b0;

    // Asynchronous reset while in service: outputs clear before any edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_svc", outs8(), 8'h00);
    step();
    rst_n = 1'b1;
    // ptr back at 0: sources 0 and 7 pending must pick 0
    isr = 8'h81;
    step();
    check("post_reset_ptr0", outs8(), pk(1, 3'd0, 0, 3'd0));
    isr = 8'h00;
    step();
    check("post_reset_withdraw", outs8(), pk(0, 3'd0, 0, 3'd0));

    // Single-source instance: ID fixed at 0, ptr wraps to 0
    ier1 = 1'b1;
    isr1 = 1'b1;
    step();
    check("n1_request", outs1(), {4'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    ack1 = 1'b1;
    step();
    ack1 = 1'b0;
    check("n1_ack", outs1(), {4'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    eoi1 = 1'b1;
    step();
    eoi1 = 1'b0;
    check("n1_eoi", outs1(), {4'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    step();
    check("n1_rerequest", outs1(), {4'b0, 1'b1, 1'b0, 1'b0, 1'b0});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
